// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request, threshold, memory-control and status bundle of the FIFO controller
interface fifo_ctrl_if #(
    parameter int MAIN_SIZE = 4
);
    logic                 push;
    logic                 pop;
    logic [MAIN_SIZE-1:0] th_low;
    logic [MAIN_SIZE-1:0] th_high;
    logic                 write;
    logic                 read;
    logic [MAIN_SIZE-1:0] wr_ptr;
    logic [MAIN_SIZE-1:0] rd_ptr;
    logic [MAIN_SIZE:0]   count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 error;
    modport master (
        output push, pop, th_low, th_high,
        input  write, read, wr_ptr, rd_ptr, count, full, empty, almost_full, almost_empty, error
    );
    modport slave (
        input  push, pop, th_low, th_high,
        output write, read, wr_ptr, rd_ptr, count, full, empty, almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_ctrl_4x8.sv
// fifo_ctrl_4x8: pointer/occupancy controller for a 2**MAIN_SIZE-entry FIFO driving an external memory
module fifo_ctrl_4x8 #(
    parameter int MAIN_SIZE = 4,
    parameter int DATA_SIZE = 8
) (
    input logic        clk,
    input logic        reset,
    fifo_ctrl_if.slave bus
);
    localparam logic [MAIN_SIZE:0] DEPTH = (MAIN_SIZE+1)'(2**MAIN_SIZE);
    if (MAIN_SIZE < 1 || DATA_SIZE < 1) begin : g_bad_params
        $error("fifo_ctrl_4x8: MAIN_SIZE and DATA_SIZE must be positive");
    end
    logic [MAIN_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, th_low_q, th_high_q;
    logic [MAIN_SIZE:0]   count_q, count_d;
    logic                 error_q, error_d;
    logic                 full, empty, wr_acc, rd_acc;
    always_comb begin
        full     = count_q == DEPTH;
        empty    = count_q == '0;
        wr_acc   = !reset && bus.push && (!full || bus.pop);
        rd_acc   = !reset && bus.pop && !empty;
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                   (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
        error_d  = error_q || (bus.push && !wr_acc) || (bus.pop && !rd_acc);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
            th_low_q  <= bus.th_low;
            th_high_q <= bus.th_high;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            error_q   <= error_d;
        end
    end
    assign bus.write        = wr_acc;
    assign bus.read         = rd_acc;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    // a zero high threshold means "any occupancy short of full"
    assign bus.almost_full  = !full && (th_high_q == '0 ? !empty : count_q >= {1'b0, th_high_q});
    assign bus.almost_empty = !empty && count_q <= {1'b0, th_low_q};
    assign bus.error        = error_q;
endmodule
